// File: rtl/aplic_msi_scheduler.sv
// MSI delivery sequencer for one APLIC domain: round-robin chunk scan, target lookup, one MSI at a time.
// Optional AIA_MSI_SCHED_STATS_EN adds o_sent_cnt, a wrapping count of accepted MSI writes.
module aplic_msi_scheduler #(
  parameter int NR_SRC   = 256,
  parameter int NR_HARTS = 2,
  parameter int EIID_W   = 11,
  parameter int HART_W   = (NR_HARTS > 1) ? $clog2(NR_HARTS) : 1,
  parameter int SRC_W    = $clog2(NR_SRC)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_domain_ie,
  input  logic [NR_SRC-1:0] i_pending,
  input  logic [NR_SRC-1:0] i_enabled,
  output logic [SRC_W-1:0]  o_tgt_idx,
  input  logic [HART_W-1:0] i_tgt_hart,
  input  logic [EIID_W-1:0] i_tgt_eiid,
  output logic              o_msi_valid,
  input  logic              i_msi_ready,
  output logic [HART_W-1:0] o_msi_hart,
  output logic [EIID_W-1:0] o_msi_eiid,
  output logic              o_clr_valid,
  output logic [SRC_W-1:0]  o_clr_idx,
`ifdef AIA_MSI_SCHED_STATS_EN
  output logic [31:0]       o_sent_cnt,
`endif
  output logic              o_drop
);

  localparam int NCHUNK = NR_SRC / 32;
  localparam int PTR_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_LOOKUP, S_SEND} state_e;

  state_e              state_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [SRC_W-1:0]    idx_q;
  logic                msi_valid_q, clr_valid_q, drop_q;
  logic [HART_W-1:0]   msi_hart_q;
  logic [EIID_W-1:0]   msi_eiid_q;
  logic [SRC_W-1:0]    clr_idx_q;

  logic [NR_SRC-1:0]            hit;
  logic [NCHUNK-1:0][31:0]      hit_chunks;
  logic [31:0]                  chunk;
  logic [4:0]                   lo;
  logic [SRC_W-1:0]             scan_idx;
  logic [PTR_W-1:0]             idx_ptr;
  logic                         tgt_bad;

  // Source 0 is architecturally invalid and can never be delivered.
  assign hit        = i_pending & i_enabled & ~NR_SRC'(1);
  assign hit_chunks = hit;
  assign chunk      = hit_chunks[ptr_q];

  always_comb begin
    lo = '0;
    for (int i = 31; i >= 0; i--)
      if (chunk[i]) lo = 5'(i);
  end

  assign scan_idx = SRC_W'({ptr_q, lo});
  assign idx_ptr  = PTR_W'(idx_q >> 5);
  assign tgt_bad  = (i_tgt_eiid == '0) ||
                    ({{(32-HART_W){1'b0}}, i_tgt_hart} >= 32'(NR_HARTS));

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == NCHUNK - 1) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      msi_valid_q <= 1'b0;
      clr_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      msi_hart_q  <= '0;
      msi_eiid_q  <= '0;
      clr_idx_q   <= '0;
    end else begin
      clr_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      case (state_q)
        S_IDLE: if (i_domain_ie) state_q <= S_SCAN;
        S_SCAN: begin
          if (!i_domain_ie) state_q <= S_IDLE;
          else if (|chunk) begin
            idx_q   <= scan_idx;
            state_q <= S_LOOKUP;
          end else ptr_q <= wrap_inc(ptr_q);
        end
        S_LOOKUP: begin
          if (!i_domain_ie) state_q <= S_IDLE;
          else if (!hit[idx_q]) state_q <= S_SCAN;
          else if (tgt_bad) begin
            clr_valid_q <= 1'b1;
            drop_q      <= 1'b1;
            clr_idx_q   <= idx_q;
            ptr_q       <= wrap_inc(idx_ptr);
            state_q     <= S_SCAN;
          end else begin
            msi_hart_q  <= i_tgt_hart;
            msi_eiid_q  <= i_tgt_eiid;
            msi_valid_q <= 1'b1;
            state_q     <= S_SEND;
          end
        end
        S_SEND: begin
          // Committed request: IE or pending changes here do not retract valid.
          if (i_msi_ready) begin
            msi_valid_q <= 1'b0;
            clr_valid_q <= 1'b1;
            clr_idx_q   <= idx_q;
            ptr_q       <= wrap_inc(idx_ptr);
            state_q     <= i_domain_ie ? S_SCAN : S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_tgt_idx   = idx_q;
  assign o_msi_valid = msi_valid_q;
  assign o_msi_hart  = msi_hart_q;
  assign o_msi_eiid  = msi_eiid_q;
  assign o_clr_valid = clr_valid_q;
  assign o_clr_idx   = clr_idx_q;
  assign o_drop      = drop_q;

`ifdef AIA_MSI_SCHED_STATS_EN
  logic [31:0] sent_cnt_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sent_cnt_q <= '0;
    else if (msi_valid_q && i_msi_ready) sent_cnt_q <= sent_cnt_q + 32'd1;
  end
  assign o_sent_cnt = sent_cnt_q;
`endif

endmodule

// File: tb/tb_aplic_msi_scheduler.sv
// Directed bench for aplic_msi_scheduler; a small source-state model clears pending on o_clr_valid.
module tb_aplic_msi_scheduler;
  localparam int NR_SRC = 256, NR_HARTS = 2, EIID_W = 11, HART_W = 2, SRC_W = 8;

  logic clk = 1'b0, rst = 1'b1, ie = 1'b0, ready = 1'b0;
  logic [NR_SRC-1:0] pending = '0, enabled = '1;
  logic [SRC_W-1:0]  tgt_idx, clr_idx;
  logic [HART_W-1:0] tgt_hart, msi_hart;
  logic [EIID_W-1:0] tgt_eiid, msi_eiid;
  logic msi_valid, clr_valid, drop;
`ifdef AIA_MSI_SCHED_STATS_EN
  logic [31:0] sent_cnt;
`endif

  int checks = 0, errors = 0, cyc_n = 0, stab_err = 0, mark = 0;
  int snd_eiid[$], snd_hart[$], snd_idx[$], snd_cyc[$], clr_i[$], clr_d[$], clr_c[$];
  bit flag;

  aplic_msi_scheduler #(.NR_SRC(NR_SRC), .NR_HARTS(NR_HARTS), .EIID_W(EIID_W),
                        .HART_W(HART_W), .SRC_W(SRC_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_domain_ie(ie), .i_pending(pending), .i_enabled(enabled),
    .o_tgt_idx(tgt_idx), .i_tgt_hart(tgt_hart), .i_tgt_eiid(tgt_eiid),
    .o_msi_valid(msi_valid), .i_msi_ready(ready), .o_msi_hart(msi_hart), .o_msi_eiid(msi_eiid),
    .o_clr_valid(clr_valid), .o_clr_idx(clr_idx),
`ifdef AIA_MSI_SCHED_STATS_EN
    .o_sent_cnt(sent_cnt),
`endif
    .o_drop(drop));

  always #5 clk = ~clk;

  // Target table: hart 1, EIID = src+2; src 12 has EIID 0, src 13 an out-of-range hart.
  always_comb begin
    tgt_hart = (tgt_idx == 8'd13) ? 2'd2 : 2'd1;
    tgt_eiid = (tgt_idx == 8'd12) ? '0 : EIID_W'(int'(tgt_idx) + 2);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // One clock: log a handshake about to happen, then sample at the next negedge.
  task automatic cyc();
    logic hs, pv;
    logic [HART_W-1:0] ph;
    logic [EIID_W-1:0] pe;
    logic [SRC_W-1:0]  pi;
    hs = msi_valid && ready;
    pv = msi_valid; ph = msi_hart; pe = msi_eiid; pi = tgt_idx;
    if (hs) begin
      snd_hart.push_back(int'(msi_hart)); snd_eiid.push_back(int'(msi_eiid));
      snd_idx.push_back(int'(tgt_idx));   snd_cyc.push_back(cyc_n);
    end
    @(negedge clk); cyc_n++;
    if (pv && !hs && (!msi_valid || msi_hart !== ph || msi_eiid !== pe || tgt_idx !== pi))
      stab_err++;
    if (drop && !clr_valid) stab_err++;
    if (clr_valid) begin
      clr_i.push_back(int'(clr_idx)); clr_d.push_back(int'(drop)); clr_c.push_back(cyc_n);
      pending[clr_idx] = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1; ie = 1'b0; ready = 1'b0; pending = '0;
    @(negedge clk); @(negedge clk); cyc_n += 2;
    rst = 1'b0;
    snd_eiid.delete(); snd_hart.delete(); snd_idx.delete(); snd_cyc.delete();
    clr_i.delete(); clr_d.delete(); clr_c.delete();
  endtask

  initial begin
    // Reset values
    @(negedge clk); cyc_n++;
    chk("rst_valid", msi_valid, 0); chk("rst_clr", clr_valid, 0); chk("rst_drop", drop, 0);
    chk("rst_tgt", tgt_idx, 0);     chk("rst_hart", msi_hart, 0); chk("rst_eiid", msi_eiid, 0);
    chk("rst_clridx", clr_idx, 0);
    do_reset();

    // Single source 5
    pending[5] = 1'b1; ie = 1'b1; ready = 1'b1; mark = cyc_n;
    cyc(); cyc();
    chk("t1_lookup_idx", tgt_idx, 5);
    run(10);
    chk("t1_nsend", snd_eiid.size(), 1);
    chk("t1_hart", q_at(snd_hart, 0), 1);
    chk("t1_eiid", q_at(snd_eiid, 0), 7);
    chk("t1_valid_cyc", q_at(snd_cyc, 0), mark + 3);
    chk("t1_nclr", clr_i.size(), 1);
    chk("t1_clr_idx", q_at(clr_i, 0), 5);
    chk("t1_clr_cyc", q_at(clr_c, 0), mark + 4);
    chk("t1_nodrop", q_at(clr_d, 0), 0);

    // Round-robin 3 / 40, then 3 re-pended while 40 waits
    do_reset();
    pending[3] = 1'b1; pending[40] = 1'b1; ie = 1'b1; ready = 1'b1; flag = 0;
    for (int k = 0; k < 60; k++) begin
      cyc();
      if (!flag && clr_i.size() >= 1) begin pending[3] = 1'b1; flag = 1; end
    end
    chk("t2_nsend", snd_eiid.size(), 3);
    chk("t2_eiid0", q_at(snd_eiid, 0), 5);
    chk("t2_eiid1", q_at(snd_eiid, 1), 42);
    chk("t2_eiid2", q_at(snd_eiid, 2), 5);
    chk("t2_clr0", q_at(clr_i, 0), 3);
    chk("t2_clr1", q_at(clr_i, 1), 40);
    chk("t2_clr2", q_at(clr_i, 2), 3);

    // Backpressure with IE drop and pending clear mid-wait
    do_reset();
    pending[9] = 1'b1; ie = 1'b1; ready = 1'b0;
    run(3);
    chk("t3_valid", msi_valid, 1); chk("t3_hart", msi_hart, 1); chk("t3_eiid", msi_eiid, 11);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin ie = 1'b0; pending[9] = 1'b0; end
      cyc();
    end
    chk("t3_held_valid", msi_valid, 1); chk("t3_held_eiid", msi_eiid, 11);
    chk("t3_nosend_yet", snd_eiid.size(), 0);
    ready = 1'b1;
    run(6);
    chk("t3_nsend", snd_eiid.size(), 1);
    chk("t3_send_eiid", q_at(snd_eiid, 0), 11);
    chk("t3_nclr", clr_i.size(), 1);
    chk("t3_clr_idx", q_at(clr_i, 0), 9);
    pending[9] = 1'b1;
    run(10);
    chk("t3_idle_nsend", snd_eiid.size(), 1);
    chk("t3_idle_valid", msi_valid, 0);

    // Drops: 12 (EIID 0) then 13 (hart 2)
    do_reset();
    pending[12] = 1'b1; pending[13] = 1'b1; ie = 1'b1; ready = 1'b1; mark = cyc_n;
    run(30);
    chk("t4_nsend", snd_eiid.size(), 0);
    chk("t4_nclr", clr_i.size(), 2);
    chk("t4_clr0", q_at(clr_i, 0), 12); chk("t4_drop0", q_at(clr_d, 0), 1);
    chk("t4_cyc0", q_at(clr_c, 0), mark + 3);
    chk("t4_clr1", q_at(clr_i, 1), 13); chk("t4_drop1", q_at(clr_d, 1), 1);
    chk("t4_cyc1", q_at(clr_c, 1), mark + 12);

    // Source 0 never served; 255 then 1 across the pointer wrap
    do_reset();
    pending[0] = 1'b1; ie = 1'b1; ready = 1'b1;
    run(20);
    chk("t5_src0_nsend", snd_eiid.size(), 0);
    chk("t5_src0_nclr", clr_i.size(), 0);
    pending[255] = 1'b1; flag = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (!flag && snd_eiid.size() >= 1) begin pending[1] = 1'b1; flag = 1; end
    end
    chk("t5_nsend", snd_eiid.size(), 2);
    chk("t5_eiid0", q_at(snd_eiid, 0), 257);
    chk("t5_eiid1", q_at(snd_eiid, 1), 3);
    chk("t5_clr0", q_at(clr_i, 0), 255);
    chk("t5_clr1", q_at(clr_i, 1), 1);
    chk("t5_wrap_gap", q_at(clr_c, 1) - q_at(clr_c, 0), 3);
    chk("t5_src0_pend", pending[0], 1);

    // Asynchronous reset while in SEND
    do_reset();
    pending[20] = 1'b1; ie = 1'b1; ready = 1'b0;
    run(3);
    chk("t6_valid", msi_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_valid", msi_valid, 0); chk("t6_async_clr", clr_valid, 0);
    chk("t6_async_eiid", msi_eiid, 0);
    @(negedge clk); @(negedge clk); cyc_n += 2;
    rst = 1'b0; ready = 1'b1; mark = cyc_n;
    cyc();
    chk("t6_noclr", clr_i.size(), 0);
    chk("t6_still_pend", pending[20], 1);
    run(7);
    chk("t6_nsend", snd_eiid.size(), 1);
    chk("t6_resend_cyc", q_at(snd_cyc, 0), mark + 3);
    chk("t6_eiid", q_at(snd_eiid, 0), 22);

    chk("stability", stab_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aplic_msi_scheduler.md
# aplic_msi_scheduler

Sequences MSI delivery for one APLIC interrupt domain in MSI mode. It scans the domain's pending-and-enabled source vector and looks up each hit's target (hart index, EIID). It then issues one MSI write request at a time to the IMSIC-facing write port with a valid/ready handshake, and clears the source's pending bit on acceptance. It sits between the domain's source-state registers and target registers on one side and the MSI bus master that writes IMSIC interrupt files on the other.

## Interface
Parameters:
- NR_SRC, 256, number of source slots including invalid source 0; must be a multiple of 32.
- NR_HARTS, 2, number of addressable harts.
- EIID_W, 11, EIID width.
- HART_W, $clog2(NR_HARTS) (min 1), hart index width.
- SRC_W, $clog2(NR_SRC), source index width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_domain_ie  in  1  domaincfg.IE.
- i_pending  in  NR_SRC  per-source pending bits.
- i_enabled  in  NR_SRC  per-source enable bits.
- o_tgt_idx  out  SRC_W  source whose target register is read.
- i_tgt_hart  in  HART_W  target hart of o_tgt_idx (combinational lookup).
- i_tgt_eiid  in  EIID_W  target EIID of o_tgt_idx.
- o_msi_valid  out  1  MSI request valid.
- i_msi_ready  in  1  MSI master accepts.
- o_msi_hart  out  HART_W  destination hart.
- o_msi_eiid  out  EIID_W  EIID to write.
- o_clr_valid  out  1  one-cycle pulse: clear pending of o_clr_idx.
- o_clr_idx  out  SRC_W  source to clear.
- o_drop  out  1  one-cycle pulse: source dropped (EIID 0 or hart out of range).

## Operation
- Hit vector = i_pending & i_enabled, with bit 0 forced to 0.
- Chunk pointer ptr (width $clog2(NR_SRC/32)) selects 32 sources per cycle; wraps from last chunk to 0.
- FSM states:
  - IDLE: all outputs idle. Go to SCAN when i_domain_ie=1.
  - SCAN: if i_domain_ie=0, go to IDLE. If chunk ptr has any hit, latch idx = lowest hit index in chunk and go to LOOKUP. Otherwise ptr+1 and stay.
  - LOOKUP: o_tgt_idx=idx.
    - If i_domain_ie=0, go to IDLE.
    - If hit[idx]=0 (cleared externally), go to SCAN; ptr unchanged.
    - If i_tgt_eiid==0 or i_tgt_hart>=NR_HARTS: pulse o_clr_valid and o_drop, set ptr=chunk(idx)+1, go to SCAN.
    - Otherwise register hart/EIID and go to SEND.
  - SEND: o_msi_valid=1; hart, EIID and idx held stable. On valid&ready: pulse o_clr_valid with o_clr_idx=idx next cycle, set ptr=chunk(idx)+1 (wrap), go to SCAN (IDLE if i_domain_ie=0).
- Fairness: round-robin across chunks, lowest index within a chunk.
- Once o_msi_valid is raised it is never retracted; IE drop or pending clear during SEND does not abort it.
- Reset mid-transfer: everything returns to reset values immediately; a pending MSI is abandoned and the bit stays pending.

## Timing
- Reset values: state IDLE, ptr 0, idx 0, o_msi_valid 0, o_clr_valid 0, o_drop 0, o_msi_hart 0, o_msi_eiid 0, o_tgt_idx 0, o_clr_idx 0.
- Hit found in SCAN at cycle t: LOOKUP at t+1, o_msi_valid at t+2.
- Ready high on the first valid cycle: o_clr_valid at t+3, SCAN at t+3.
- Worst-case scan: NR_SRC/32 cycles per sweep.
- o_clr_valid and o_drop are registered single-cycle pulses. The source-state logic must apply the clear before the next SCAN sample of that chunk; the pointer advance guarantees at least one cycle.

## Configuration
- AIA_MSI_SCHED_STATS_EN defined: adds o_sent_cnt (out, 32), which increments on each MSI handshake, wraps at 2^32-1 to 0, and resets to 0.
- Macro undefined: the port and counter are absent.

## Test plan
- Single source: IE=1, pending/enabled bit 5, target hart 1, EIID 7, ready=1 -> exactly one MSI (hart 1, EIID 7); o_clr_valid with idx 5 three cycles after the SCAN hit.
- Round-robin: sources 3 and 40 pending, ready=1 -> MSI for 3, then 40. Re-pend 3 after the first clear while 40 is still pending -> 40 is served before 3.
- Backpressure: ready=0 for 10 cycles with source 9 pending, deassert IE and clear pending at cycle 4 -> valid, hart and EIID stable throughout; single MSI and clear after ready rises; FSM goes to IDLE.
- Drop: source 12 with EIID 0, and source 13 with hart 2 (NR_HARTS=2) -> no o_msi_valid; o_drop and o_clr_valid pulse for 12, then for 13.
- Source 0 and wrap: only bit 0 pending -> never served. Source 255 and then source 1 pending -> 255 then 1, with ptr wrapping to 0.
- Reset in SEND: assert i_rst while o_msi_valid=1 -> o_msi_valid=0 asynchronously, FSM IDLE, no clear pulse.
